// File: rtl/rca_result_display_pkg.sv
`default_nettype none
// ============================================================================
// Package : rca_disp_pkg
// Purpose : Shared types and constants for the adder result display.
//           Holds the conversion FSM state type, the active-low segment
//           patterns {g,f,e,d,c,b,a}, the display geometry and the
//           double-dabble nibble adjust helper.
// Revision: 1.0  initial release
// ============================================================================
package rca_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int RESULT_W   = 17;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Add 3 to every BCD nibble that is 5 or more, so the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_result_display_if.sv
`default_nettype none
// ============================================================================
// Interface: rca_result_display_if
// Purpose  : Bundles the adder-result input, the conversion status and the
//            seven-segment drive of rca_result_display.
//   load      : capture strobe (master -> slave)
//   sum_in    : 16-bit adder sum (master -> slave)
//   cout_in   : adder carry, bit 16 of the value (master -> slave)
//   busy      : conversion in progress (slave -> master)
//   bcd_valid : one-cycle commit pulse (slave -> master)
//   an/seg/dp : active-low anode, segment and decimal point drive
// Revision : 1.0  initial release
// ============================================================================
interface rca_result_display_if;
  logic        load;
  logic [15:0] sum_in;
  logic        cout_in;
  logic        busy;
  logic        bcd_valid;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output load, sum_in, cout_in,
    input  busy, bcd_valid, an, seg, dp
  );

  modport slave (
    input  load, sum_in, cout_in,
    output busy, bcd_valid, an, seg, dp
  );
endinterface
`default_nettype wire

// File: rtl/rca_result_display_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_7seg
// Purpose : Combinational BCD digit to active-low seven-segment decode.
//           Codes above 9 show nothing.
//   bcd_i : 4-bit BCD digit
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
// Revision: 1.0  initial release
// ============================================================================
module bcd_to_7seg
  import rca_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rca_result_display.sv
`default_nettype none
// ============================================================================
// Module  : rca_result_display
// Purpose : Captures the 17-bit {Cout, Sum} result of the ripple-carry adder,
//           converts it to six BCD digits with a sequential double-dabble
//           engine (17 iterations) and time-multiplexes the digits onto the
//           eight-digit seven-segment display with leading-zero blanking.
//   Clk : system clock, rising edge
//   Rs  : synchronous active-high reset
//   bus : rca_result_display_if.slave (load/sum_in/cout_in in,
//         busy/bcd_valid/an/seg/dp out)
//   REFRESH_DIV : clock cycles per digit slot (minimum 2)
// Revision: 1.0  initial release
// ============================================================================
module rca_result_display
  import rca_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
)
(
  input  logic                 Clk,
  input  logic                 Rs,
  rca_result_display_if.slave  bus
);

  localparam int         CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [4:0] LAST_ITER = 5'(RESULT_W - 1);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);

  // Conversion engine state
  state_t              state_q;
  logic [RESULT_W-1:0] bin_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [4:0]          iter_q;
  logic                busy_q;
  logic                valid_q;
  logic [BCD_W-1:0]    disp_q;
  logic [BCD_W-1:0]    disp_d;
  logic [BCD_W-1:0]    bcd_adj;

  // Scanner state
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          idx_q;
  logic [7:0]          an_q;
  logic [6:0]          seg_q;
  logic [7:0]          lead_blank;
  logic [3:0]          slot_digit;
  logic [6:0]          slot_seg;

  assign bcd_adj = dd_adjust(bcd_q);

  // The display register only moves in COMMIT. The scanner looks at the
  // next value so a commit landing on a slot change shows the new digit.
  assign disp_d = (state_q == COMMIT) ? bcd_q : disp_q;

  // --------------------------------------------------------------------------
  // Conversion FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rs) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      disp_q  <= disp_d;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            bin_q   <= {bus.cout_in, bus.sum_in};
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        CONVERT: begin
          // One double-dabble step: adjust, then shift {bcd, bin} left.
          bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[RESULT_W-1]};
          bin_q  <= {bin_q[RESULT_W-2:0], 1'b0};
          iter_q <= iter_q + 5'd1;
          if (iter_q == LAST_ITER) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          // busy stays high through this cycle; it drops on the next IDLE edge
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero blanking: digit k>0 is blank when digits k..5 are all zero
  // --------------------------------------------------------------------------
  always_comb begin
    logic all_zero;
    lead_blank = '0;
    all_zero   = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      all_zero      = all_zero & (disp_d[4*k +: 4] == 4'd0);
      lead_blank[k] = all_zero;
    end
  end

  assign slot_digit = disp_d[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd_i (slot_digit),
    .seg_o (slot_seg)
  );

  // --------------------------------------------------------------------------
  // Scanner: outputs reload on the first cycle of each slot (cnt_q == 0),
  // so every slot, including the first after reset, lasts REFRESH_DIV cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rs) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (cnt_q == '0) begin
        if (lead_blank[idx_q]) begin
          an_q  <= 8'hFF;
          seg_q <= SEG_BLANK;
        end else begin
          an_q  <= ~(8'b0000_0001 << idx_q);
          seg_q <= slot_seg;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bcd_valid = valid_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_rca_result_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_rca_result_display
// Purpose : Directed self-checking bench for rca_result_display with
//           REFRESH_DIV=4: reset state, conversions of 0, 131071, 305, 9 and
//           42, load-while-busy, reset abort and scan ordering.
// Revision: 1.0  initial release
// ============================================================================
module tb_rca_result_display;

  localparam int REFRESH_DIV = 4;

  logic Clk = 1'b0;
  logic Rs;
  int   vectors     = 0;
  int   miscompares = 0;

  rca_result_display_if bus ();

  rca_result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .Clk (Clk),
    .Rs  (Rs),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input logic [47:0] obs, input logic [47:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sync to the first cycle of digit slot 0, then check each of the six slots.
  task automatic check_scan(input logic [47:0] ean, input logic [41:0] eseg, input string tag);
    logic [7:0] prev;
    logic       found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = bus.an;
      step();
      if (bus.an == 8'hFE && prev != 8'hFE) found = 1'b1;
    end
    chk({47'd0, found}, 48'd1, {tag, "_sync"});
    if (found) begin
      for (int s = 0; s < 6; s++) begin
        if (s > 0) repeat (REFRESH_DIV) step();
        chk({40'd0, bus.an},  {40'd0, ean[8*s +: 8]},  $sformatf("%s_an%0d", tag, s));
        chk({41'd0, bus.seg}, {41'd0, eseg[7*s +: 7]}, $sformatf("%s_seg%0d", tag, s));
      end
    end
  endtask

  // Load at edge 0; optional second load at edge extra_k; optional reset
  // (with load also high) at edge abort_k. Checks busy/bcd_valid per edge.
  task automatic convert(input logic [15:0] s, input logic c, input int extra_k,
                         input logic [15:0] extra_s, input int abort_k, input string tag);
    logic exp_busy, exp_valid;
    bus.load    = 1'b1;
    bus.sum_in  = s;
    bus.cout_in = c;
    step();
    bus.load = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == extra_k) begin
        bus.load   = 1'b1;
        bus.sum_in = extra_s;
      end
      if (k == abort_k) begin
        Rs       = 1'b1;
        bus.load = 1'b1;
      end
      step();
      bus.load = 1'b0;
      Rs       = 1'b0;
      exp_busy  = (abort_k != 0) ? (k < abort_k) : (k <= 18);
      exp_valid = (abort_k == 0) && (k == 18);
      chk({47'd0, bus.busy},      {47'd0, exp_busy},  $sformatf("%s_busy_e%0d", tag, k));
      chk({47'd0, bus.bcd_valid}, {47'd0, exp_valid}, $sformatf("%s_valid_e%0d", tag, k));
    end
  endtask

  initial begin
    logic [7:0] prev_an;
    logic [7:0] exp_next;
    int         changes;

    Rs          = 1'b1;
    bus.load    = 1'b0;
    bus.sum_in  = 16'd0;
    bus.cout_in = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk({40'd0, bus.an},  48'hFF, "rst_an");
      chk({41'd0, bus.seg}, 48'h7F, "rst_seg");
      chk({47'd0, bus.busy}, 48'd0, "rst_busy");
      chk({47'd0, bus.bcd_valid}, 48'd0, "rst_valid");
      chk({47'd0, bus.dp}, 48'd1, "rst_dp");
    end
    Rs = 1'b0;
    step();
    chk({40'd0, bus.an},  48'hFE, "first_an");
    chk({41'd0, bus.seg}, 48'h40, "first_seg");
    check_scan({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, "zero");

    // 131071: digits 0..5 = 1,7,0,1,3,1
    convert(16'hFFFF, 1'b1, 0, 16'd0, 0, "max");
    check_scan({8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
               {7'h79, 7'h30, 7'h79, 7'h40, 7'h78, 7'h79}, "max");

    // Scan ordering over 30 refresh periods
    changes = 0;
    prev_an = bus.an;
    for (int i = 0; i < 30 * REFRESH_DIV; i++) begin
      step();
      if (bus.an[7:6] != 2'b11) begin
        chk({46'd0, bus.an[7:6]}, 48'd3, "wrap_an76");
      end
      if (bus.an != prev_an) begin
        exp_next = (prev_an == 8'hDF) ? 8'hFE : {prev_an[6:0], 1'b1};
        chk({40'd0, bus.an}, {40'd0, exp_next}, "wrap_order");
        changes++;
      end
      prev_an = bus.an;
    end
    chk(48'(changes >= 29), 48'd1, "wrap_count");

    // 305: digits 5,0,3 with 3..5 blank, interior zero shown
    convert(16'd305, 1'b0, 0, 16'd0, 0, "d305");
    check_scan({8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE},
               {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}, "d305");

    // 9 with an ignored second load of 1234 at edge 5
    convert(16'd9, 1'b0, 5, 16'd1234, 0, "d9");
    check_scan({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}, "d9");

    // Reset (with load) at edge 10 aborts the conversion
    convert(16'hFFFF, 1'b1, 0, 16'd0, 10, "abort");
    check_scan({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, "abort");

    // Fresh load after abort
    convert(16'd42, 1'b0, 0, 16'd0, 0, "d42");
    check_scan({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, "d42");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
